// File: rtl/enemy_tank_mover.sv
// Enemy tank motion: paces steps off a tick timer, pauses on turns, stops at bounds or obstacles.
// Optional: define MOVER_WRAP_EN to wrap across play-field bounds instead of clamping.
module enemy_tank_mover #(
  parameter int unsigned STEP_DIV   = 833333,
  parameter int unsigned STEP_PX    = 2,
  parameter int unsigned TURN_TICKS = 4,
  parameter int unsigned X_MIN      = 0,
  parameter int unsigned X_MAX      = 1248,
  parameter int unsigned Y_MIN      = 0,
  parameter int unsigned Y_MAX      = 992,
  parameter int unsigned INIT_X     = 64,
  parameter int unsigned INIT_Y     = 64,
  parameter int unsigned INIT_DIR   = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        respawn,
  input  logic [1:0]  direction,
  input  logic        blocked,
  output logic [10:0] blkpos_x,
  output logic [9:0]  blkpos_y,
  output logic [1:0]  heading,
  output logic        moving,
  output logic        step_pulse,
  output logic        bump_pulse
);

  localparam int unsigned CntW = $clog2(STEP_DIV);
  localparam logic [CntW-1:0] CntLast = CntW'(STEP_DIV - 1);
  localparam logic [7:0]  TurnInit = 8'(TURN_TICKS);
  localparam logic [11:0] XMinW    = 12'(X_MIN);
  localparam logic [11:0] XMaxW    = 12'(X_MAX);
  localparam logic [11:0] StepXW   = 12'(STEP_PX);
  localparam logic [10:0] YMinW    = 11'(Y_MIN);
  localparam logic [10:0] YMaxW    = 11'(Y_MAX);
  localparam logic [10:0] StepYW   = 11'(STEP_PX);
  localparam logic [10:0] InitX    = 11'(INIT_X);
  localparam logic [9:0]  InitY    = 10'(INIT_Y);
  localparam logic [1:0]  InitDir  = 2'(INIT_DIR);

  localparam logic [1:0] DirUp    = 2'd0;
  localparam logic [1:0] DirDown  = 2'd1;
  localparam logic [1:0] DirRight = 2'd2;
  localparam logic [1:0] DirLeft  = 2'd3;

`ifdef MOVER_WRAP_EN
  localparam bit ClampEn = 1'b0;
`else
  localparam bit ClampEn = 1'b1;
`endif

  typedef enum logic [1:0] {StIdle, StMove, StTurn, StBlocked} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [7:0]      turn_q, turn_d;
  logic [10:0]     x_q, x_d;
  logic [9:0]      y_q, y_d;
  logic [1:0]      heading_q, heading_d;
  logic            moving_q, moving_d;
  logic            step_q, step_d;
  logic            bump_q, bump_d;

  logic        tick;
  logic [11:0] nx_w;
  logic [10:0] ny_w;
  logic [10:0] cand_x;
  logic [9:0]  cand_y;
  logic        over;
  logic        on_bound;
  logic        at_bound;

  assign tick = enable && (cnt_q == CntLast);

  // Candidate position for one step along the current heading; one bit wider to catch underflow.
  always_comb begin
    nx_w     = {1'b0, x_q};
    ny_w     = {1'b0, y_q};
    cand_x   = x_q;
    cand_y   = y_q;
    over     = 1'b0;
    on_bound = 1'b0;
    case (heading_q)
      DirUp: begin
        ny_w     = {1'b0, y_q} - StepYW;
        over     = ny_w[10] || (ny_w < YMinW);
        on_bound = ({1'b0, y_q} == YMinW);
        cand_y   = !over ? ny_w[9:0] : (ClampEn ? YMinW[9:0] : YMaxW[9:0]);
      end
      DirDown: begin
        ny_w     = {1'b0, y_q} + StepYW;
        over     = ny_w > YMaxW;
        on_bound = ({1'b0, y_q} == YMaxW);
        cand_y   = !over ? ny_w[9:0] : (ClampEn ? YMaxW[9:0] : YMinW[9:0]);
      end
      DirRight: begin
        nx_w     = {1'b0, x_q} + StepXW;
        over     = nx_w > XMaxW;
        on_bound = ({1'b0, x_q} == XMaxW);
        cand_x   = !over ? nx_w[10:0] : (ClampEn ? XMaxW[10:0] : XMinW[10:0]);
      end
      DirLeft: begin
        nx_w     = {1'b0, x_q} - StepXW;
        over     = nx_w[11] || (nx_w < XMinW);
        on_bound = ({1'b0, x_q} == XMinW);
        cand_x   = !over ? nx_w[10:0] : (ClampEn ? XMinW[10:0] : XMaxW[10:0]);
      end
      default: ;
    endcase
    at_bound = ClampEn && on_bound;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = (respawn || !enable || tick) ? '0 : cnt_q + 1'b1;
    turn_d    = turn_q;
    x_d       = x_q;
    y_d       = y_q;
    heading_d = heading_q;
    step_d    = 1'b0;
    bump_d    = 1'b0;
    if (respawn) begin
      state_d   = StIdle;
      turn_d    = '0;
      x_d       = InitX;
      y_d       = InitY;
      heading_d = InitDir;
    end else if (!enable) begin
      state_d = StIdle;
      turn_d  = '0;
    end else if (state_q == StIdle) begin
      state_d = StMove;
    end else if (tick && (direction != heading_q)) begin
      // Any heading change restarts the turn pause, whatever state we were in.
      heading_d = direction;
      if (TurnInit == 8'd0) begin
        state_d = StMove;
        turn_d  = '0;
      end else begin
        state_d = StTurn;
        turn_d  = TurnInit;
      end
    end else if (tick) begin
      case (state_q)
        StMove: begin
          if (blocked) begin
            state_d = StBlocked;
            bump_d  = 1'b1;
          end else begin
            x_d    = cand_x;
            y_d    = cand_y;
            step_d = (cand_x != x_q) || (cand_y != y_q);
            if (over && ClampEn) begin
              state_d = StBlocked;
              bump_d  = 1'b1;
            end
          end
        end
        StTurn: begin
          turn_d = (turn_q == 8'd0) ? 8'd0 : turn_q - 8'd1;
          if (turn_q <= 8'd1) state_d = StMove;
        end
        StBlocked: begin
          if (!blocked && !at_bound) state_d = StMove;
        end
        default: ;
      endcase
    end
    moving_d = (state_d == StMove);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      turn_q    <= '0;
      x_q       <= InitX;
      y_q       <= InitY;
      heading_q <= InitDir;
      moving_q  <= 1'b0;
      step_q    <= 1'b0;
      bump_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      turn_q    <= turn_d;
      x_q       <= x_d;
      y_q       <= y_d;
      heading_q <= heading_d;
      moving_q  <= moving_d;
      step_q    <= step_d;
      bump_q    <= bump_d;
    end
  end

  assign blkpos_x   = x_q;
  assign blkpos_y   = y_q;
  assign heading    = heading_q;
  assign moving     = moving_q;
  assign step_pulse = step_q;
  assign bump_pulse = bump_q;

endmodule
